pipe_mem_stall_ctrl: RTL and testbench

- Sequences the MEM stage of the 5-stage pipeline against a variable-latency data memory that uses a req/ack handshake.
- Detects a load or store held in the EX/MEM register and drives the memory request.
- Freezes the upstream pipeline registers and injects a bubble into MEM/WB until the access completes.
- Captures load data for writeback and flags accesses that time out.

---
 rtl/pipe_mem_stall_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_mem_stall_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_stall_ctrl.sv
// MEM-stage sequencer for a 5-stage pipeline. It talks to a variable-latency
// data memory over a req/ack handshake. While an access is outstanding it
// freezes the upstream pipeline registers and sends a bubble into MEM/WB.
// Load data is captured for writeback. An access that never gets an ack is
// forced to complete after TIMEOUT cycles and sets a sticky error flag.
module pipe_mem_stall_ctrl #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic          mwmem,
    input  logic [31:0]   malu,
    input  logic [DW-1:0] mb,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          wb_bubble,
    output logic [DW-1:0] mdata,
    output logic          err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic          load_reg;
    logic          memop;
    logic          ack_hit;
    logic          tmo_hit;

    // The register-write enable plays no part in sequencing the memory.
    // The address bits above AW are not driven onto the memory bus.
    // Both are collected here so that they are visibly ignored.
    logic unused_inputs;
    assign unused_inputs = mwreg ^ (^malu);

    assign memop   = mm2reg | mwmem;
    assign ack_hit = (state_reg == ACCESS) && mem_ack;
    assign tmo_hit = (state_reg == ACCESS) && !mem_ack && (cnt_reg == CW'(TIMEOUT - 1));

    // The pipeline is released for exactly one cycle (DONE) so MEM/WB can take mdata.
    assign stall     = memop && (state_reg != DONE);
    assign wb_bubble = stall;

    // Next-state logic: IDLE -> ACCESS on a memory op, ACCESS -> DONE on ack or timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (memop) state_next = ACCESS;
            ACCESS:  if (ack_hit || tmo_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Memory bus, timeout counter, load-data capture and the sticky error flag.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mdata     <= '0;
            err       <= 1'b0;
            cnt_reg   <= '0;
            load_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (memop) begin
                        // A combined load+store is handled as a store.
                        mem_req   <= 1'b1;
                        mem_we    <= mwmem;
                        mem_addr  <= malu[AW-1:0];
                        mem_wdata <= mb;
                        cnt_reg   <= '0;
                        load_reg  <= mm2reg && !mwmem;
                    end
                end
                ACCESS: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (ack_hit) begin
                        // An ack takes priority over a timeout in the same cycle.
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (load_reg) mdata <= mem_rdata;
                    end else if (tmo_hit) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        err     <= 1'b1;
                        if (load_reg) mdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_mem_stall_ctrl.sv
// Self-checking bench for pipe_mem_stall_ctrl. A memory model acks the
// request after a chosen number of request cycles. Each access is checked
// as one transaction: the bus contents, the stall length, mdata and err.
module tb_pipe_mem_stall_ctrl;

    localparam int TOUT = 16;

    logic        clk = 1'b0;
    logic        clrn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall, wb_bubble;
    logic [31:0] mdata;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Expected mdata and err, carried from one transaction to the next.
    logic [31:0] mdl_mdata = '0;
    logic        mdl_err   = 1'b0;

    pipe_mem_stall_ctrl #(.AW(32), .DW(32), .TIMEOUT(TOUT)) dut (
        .clk(clk), .clrn(clrn), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mb(mb), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall(stall), .wb_bubble(wb_bubble),
        .mdata(mdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rd;
        int          d;          // ack on the d-th request cycle (d > TOUT: never)
        bit          b2b;        // next op follows with no idle gap
        int          exp_stall;
        logic [31:0] exp_mdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Idle MEM slots: spurious acks must be ignored.
    task automatic idle_cycles(input int n);
        mm2reg = 1'b0;
        mwmem  = 1'b0;
        for (int i = 0; i < n; i++) begin
            mwreg     = 1'($urandom);
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
            @(negedge clk);
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_req", 32'(mem_req), 32'd0);
            chk("idle_mdata", mdata, mdl_mdata);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    // One memory op in MEM. Call at posedge+1. Returns at posedge+1 after DONE.
    task automatic do_op(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] rd, input int d,
                         input int exp_stall, input logic [31:0] exp_mdata,
                         input logic exp_err);
        int  nstall = 0;
        int  nreq   = 0;
        bit  done   = 0;
        bit  bus_ok = 1;
        bit  bub_ok = 1;
        mm2reg = ld;
        mwmem  = st;
        malu   = addr;
        mb     = data;
        mwreg  = 1'($urandom);
        for (int c = 0; c < 60 && !done; c++) begin
            if (mem_req) begin
                nreq++;
                if (mem_we !== st || mem_addr !== addr || mem_wdata !== data) bus_ok = 0;
                mem_ack = (nreq == d);
            end else begin
                mem_ack = 1'($urandom);
            end
            mem_rdata = (mem_req && mem_ack) ? rd : $urandom;
            @(negedge clk);
            if (wb_bubble !== stall) bub_ok = 0;
            if (stall) nstall++;
            else       done = 1;
            if (done) begin
                chk("done_mdata", mdata, exp_mdata);
                chk("done_err", 32'(err), 32'(exp_err));
                chk("done_req", 32'(mem_req), 32'd0);
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        chk("op_finished", 32'(done), 32'd1);
        chk("stall_cycles", 32'(nstall), 32'(exp_stall));
        chk("req_cycles", 32'(nreq), 32'(exp_stall - 1));
        chk("bus_fields", 32'(bus_ok), 32'd1);
        chk("bubble_eq_stall", 32'(bub_ok), 32'd1);
        $display("op ld=%0b st=%0b addr=%h ackdly=%0d stalls=%0d mdata=%h err=%0b",
                 ld, st, addr, d, nstall, mdata, err);
        mdl_mdata = exp_mdata;
        mdl_err   = exp_err;
    endtask

    initial begin
        clrn = 1'b0; mwreg = 0; mm2reg = 0; mwmem = 0; malu = '0; mb = '0;
        mem_ack = 0; mem_rdata = '0;

        tbl[0] = '{1, 0, 32'h100, 32'h0, 32'hCAFEF00D, 1, 0, 2, 32'hCAFEF00D, 0};
        tbl[1] = '{0, 1, 32'h200, 32'h12345678, 32'h0, 3, 0, 4, 32'hCAFEF00D, 0};
        tbl[2] = '{1, 0, 32'h300, 32'h0, 32'h11112222, 1, 1, 2, 32'h11112222, 0};
        tbl[3] = '{0, 1, 32'h304, 32'hAAAA5555, 32'h0, 1, 1, 2, 32'h11112222, 0};
        tbl[4] = '{1, 1, 32'h308, 32'h77778888, 32'h0000DEAD, 2, 0, 3, 32'h11112222, 0};
        tbl[5] = '{1, 0, 32'h400, 32'h0, 32'h0BADBEEF, 16, 0, 17, 32'h0BADBEEF, 0};
        tbl[6] = '{1, 0, 32'h500, 32'h0, 32'h99999999, 99, 0, 17, 32'h00000000, 1};
        tbl[7] = '{1, 0, 32'h600, 32'h0, 32'h5A5A5A5A, 2, 0, 3, 32'h5A5A5A5A, 1};

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mdata", mdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        clrn = 1'b1;
        idle_cycles(3);

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].ld, tbl[i].st, tbl[i].addr, tbl[i].data, tbl[i].rd, tbl[i].d,
                  tbl[i].exp_stall, tbl[i].exp_mdata, tbl[i].exp_err);
            if (!tbl[i].b2b) idle_cycles(2);
        end

        // Random ops checked against the transaction-level model.
        for (int i = 0; i < 40; i++) begin
            logic        ld, st, is_ld, tmo;
            logic [31:0] addr, data, rd, emd;
            int          d, es;
            ld    = 1'($urandom);
            st    = ld ? 1'($urandom) : 1'b1;
            addr  = $urandom;
            data  = $urandom;
            rd    = $urandom;
            d     = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 5);
            is_ld = ld && !st;
            tmo   = (d > TOUT);
            es    = (tmo ? TOUT : d) + 1;
            emd   = is_ld ? (tmo ? 32'h0 : rd) : mdl_mdata;
            do_op(ld, st, addr, data, rd, d, es, emd, mdl_err | tmo);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end

        // Asynchronous reset in the middle of an access.
        mm2reg = 1'b1; mwmem = 1'b0; malu = 32'h40; mb = '0;
        @(posedge clk); #1;
        chk("mid_req_before", 32'(mem_req), 32'd1);
        #2;
        clrn   = 1'b0;
        mm2reg = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_mdata", mdata, 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        $display("async reset during access: req=%0b stall=%0b mdata=%h err=%0b",
                 mem_req, stall, mdata, err);
        @(posedge clk); #1;
        clrn      = 1'b1;
        mdl_mdata = '0;
        mdl_err   = 1'b0;
        idle_cycles(2);
        do_op(1, 0, 32'h44, 32'h0, 32'h31415926, 1, 2, 32'h31415926, 0);
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
